// File: rtl/rf_mac_accel_if.sv
// Register-file bus for rf_mac_accel. Optional o_irq exists only when RF_ACCEL_IRQ_EN is defined.
// Bus semantics: a write happens on every rising edge with i_RF_WE high; reads have no
// handshake, and o_data always returns the register addressed in the previous cycle.
interface rf_mac_accel_if #(
  parameter int N               = 32,
  parameter int RF_ADDR_BITNESS = 3
);
  logic [RF_ADDR_BITNESS-1:0] i_addr;
  logic [N-1:0]               i_data;
  logic                       i_RF_WE;
  logic [N-1:0]               o_data;
`ifdef RF_ACCEL_IRQ_EN
  logic                       o_irq;

  modport master (output i_addr, output i_data, output i_RF_WE, input o_data, input o_irq);
  modport slave  (input i_addr, input i_data, input i_RF_WE, output o_data, output o_irq);
`else
  modport master (output i_addr, output i_data, output i_RF_WE, input o_data);
  modport slave  (input i_addr, input i_data, input i_RF_WE, output o_data);
`endif
endinterface

// File: rtl/rf_mac_accel.sv
// Register-mapped pipelined MAC: R = A*B*X + A*B*K + C (mod 2^2N), four stages, one start per cycle.
// Optional interrupt output and enable bit controlled by macro RF_ACCEL_IRQ_EN.
module rf_mac_accel #(
  parameter int          N               = 32,
  parameter int          RF_ADDR_BITNESS = 3,
  parameter int unsigned K_RESET         = 3
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  rf_mac_accel_if.slave  bus
);
  localparam int W2 = 2 * N;

  logic [N-1:0]  a_q, a_d, b_q, b_d, k_q, k_d, x_q, x_d, c_q, c_d;
  logic [N-1:0]  res_lo_q, res_lo_d, res_hi_q, res_hi_d, o_data_q, o_data_d;
  logic          done_q, done_d, ovf_q, ovf_d;
  logic          v1_q, v1_d, v2_q, v2_d, v3_q, v3_d, v4_q, v4_d;
  logic [W2-1:0] p1_q, p1_d, t1_q, t1_d, t2_q, t2_d, s3_q, s3_d, r4_q, r4_d;
  logic [N-1:0]  x1_q, x1_d, k1_q, k1_d, c1_q, c1_d, c2_q, c2_d, c3_q, c3_d;
  logic          ie_q, ie_d;
`ifdef RF_ACCEL_IRQ_EN
  logic          irq_q, irq_d;
`endif

  logic          wr_ctrl, start, clear, busy;
  logic [N-1:0]  status;

  always_comb begin
    wr_ctrl = bus.i_RF_WE && (bus.i_addr == RF_ADDR_BITNESS'(5));
    start   = wr_ctrl && bus.i_data[0];
    clear   = wr_ctrl && bus.i_data[1];

    a_d = (bus.i_RF_WE && bus.i_addr == RF_ADDR_BITNESS'(0)) ? bus.i_data : a_q;
    b_d = (bus.i_RF_WE && bus.i_addr == RF_ADDR_BITNESS'(1)) ? bus.i_data : b_q;
    k_d = (bus.i_RF_WE && bus.i_addr == RF_ADDR_BITNESS'(2)) ? bus.i_data : k_q;
    x_d = (bus.i_RF_WE && bus.i_addr == RF_ADDR_BITNESS'(3)) ? bus.i_data : x_q;
    c_d = (bus.i_RF_WE && bus.i_addr == RF_ADDR_BITNESS'(4)) ? bus.i_data : c_q;

    // Stage data always advances; only the valid bits decide what lands.
    v1_d = start;
    p1_d = {{N{1'b0}}, a_q} * {{N{1'b0}}, b_q};
    x1_d = x_q;
    k1_d = k_q;
    c1_d = c_q;

    v2_d = v1_q;
    t1_d = p1_q * {{N{1'b0}}, x1_q};
    t2_d = p1_q * {{N{1'b0}}, k1_q};
    c2_d = c1_q;

    v3_d = v2_q;
    s3_d = t1_q + t2_q;
    c3_d = c2_q;

    v4_d = v3_q;
    r4_d = s3_q + {{N{1'b0}}, c3_q};

    res_lo_d = v4_q ? r4_q[N-1:0]  : res_lo_q;
    res_hi_d = v4_q ? r4_q[W2-1:N] : res_hi_q;

    // A landing result wins over clear for done; clear always wins for ovf.
    done_d = v4_q ? 1'b1 : (clear ? 1'b0 : done_q);
    ovf_d  = clear ? 1'b0 : (ovf_q | (v4_q & done_q));

`ifdef RF_ACCEL_IRQ_EN
    ie_d  = wr_ctrl ? bus.i_data[2] : ie_q;
    irq_d = done_d & ie_d;
`else
    ie_d  = 1'b0;
`endif

    busy        = v1_q | v2_q | v3_q | v4_q;
    status      = '0;
    status[3:0] = {ie_q, ovf_q, done_q, busy};

    case (bus.i_addr)
      RF_ADDR_BITNESS'(0): o_data_d = a_q;
      RF_ADDR_BITNESS'(1): o_data_d = b_q;
      RF_ADDR_BITNESS'(2): o_data_d = k_q;
      RF_ADDR_BITNESS'(3): o_data_d = x_q;
      RF_ADDR_BITNESS'(4): o_data_d = c_q;
      RF_ADDR_BITNESS'(5): o_data_d = status;
      RF_ADDR_BITNESS'(6): o_data_d = res_lo_q;
      RF_ADDR_BITNESS'(7): o_data_d = res_hi_q;
      default:             o_data_d = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      a_q      <= '0;
      b_q      <= '0;
      k_q      <= N'(K_RESET);
      x_q      <= '0;
      c_q      <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      o_data_q <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      ie_q     <= 1'b0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      v4_q     <= 1'b0;
      p1_q     <= '0;
      t1_q     <= '0;
      t2_q     <= '0;
      s3_q     <= '0;
      r4_q     <= '0;
      x1_q     <= '0;
      k1_q     <= '0;
      c1_q     <= '0;
      c2_q     <= '0;
      c3_q     <= '0;
`ifdef RF_ACCEL_IRQ_EN
      irq_q    <= 1'b0;
`endif
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      k_q      <= k_d;
      x_q      <= x_d;
      c_q      <= c_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      o_data_q <= o_data_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      ie_q     <= ie_d;
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      v3_q     <= v3_d;
      v4_q     <= v4_d;
      p1_q     <= p1_d;
      t1_q     <= t1_d;
      t2_q     <= t2_d;
      s3_q     <= s3_d;
      r4_q     <= r4_d;
      x1_q     <= x1_d;
      k1_q     <= k1_d;
      c1_q     <= c1_d;
      c2_q     <= c2_d;
      c3_q     <= c3_d;
`ifdef RF_ACCEL_IRQ_EN
      irq_q    <= irq_d;
`endif
    end
  end

  assign bus.o_data = o_data_q;
`ifdef RF_ACCEL_IRQ_EN
  assign bus.o_irq  = irq_q;
`endif
endmodule

// File: doc/rf_mac_accel.md
RF_MAC_ACCEL -- requirements
Module: rf_mac_accel

Interface
REQ-001 Parameter N, default 32: operand width; result is 2N bits wide.
REQ-002 Parameter RF_ADDR_BITNESS, default 3, minimum 3: register-file address width.
REQ-003 Parameter K_RESET, default 3: reset value of the K coefficient register.
REQ-004 i_clk  in  1: single clock; all state changes on its rising edge.
REQ-005 i_reset_n  in  1: reset, asynchronous assert, active-low.
REQ-006 i_addr  in  RF_ADDR_BITNESS: register-file address.
REQ-007 i_data  in  N: write data.
REQ-008 i_RF_WE  in  1: write enable for the addressed register.
REQ-009 o_data  out  N: registered read data.
REQ-010 o_irq  out  1: interrupt; present only when RF_ACCEL_IRQ_EN is defined.

Function
REQ-011 Register map: 0 A, 1 B, 2 K, 3 X, 4 C (all read/write); 5 CTRL/STATUS; 6 RES_LO (read-only); 7 RES_HI (read-only); any address >= 8 reads 0 and ignores writes.
REQ-012 Read: every cycle, o_data <= the register at i_addr, one-cycle latency; a same-cycle write returns the pre-write value.
REQ-013 CTRL write bits: bit0 start; bit1 clear (clears done and ovf); bit2 ie (interrupt enable, stored only with the macro); other bits ignored.
REQ-014 STATUS read bits: bit0 busy, bit1 done, bit2 ovf, bit3 ie (reads 0 without the macro); upper bits read 0.
REQ-015 Computation: R = (A*B*X + A*B*K + C) mod 2^(2N), with C zero-extended.
REQ-016 Stage 1, at the start edge: snapshot A, B, K, X and C; P = A*B (2N bits).
REQ-017 Stage 2: T1 = P*X and T2 = P*K, each truncated to 2N bits; C is carried forward.
REQ-018 Stage 3: S = T1 + T2 mod 2^(2N); C is carried forward.
REQ-019 Stage 4: R = S + C mod 2^(2N); RES_LO <= R[N-1:0] and RES_HI <= R[2N-1:N] on the same edge.
REQ-020 Latency: a start accepted on edge t updates RES_* and sets done on edge t+4.
REQ-021 Each stage carries a valid bit; busy = OR of all four stage valids.
REQ-022 A start is accepted every cycle, including while busy, so back-to-back starts give one result per cycle.
REQ-023 Operand writes after a start do not affect in-flight operations.
REQ-024 Result landing: done <= 1; if done was already 1 and no clear is applied on that edge, ovf <= 1 (sticky).
REQ-025 Clear and result landing on the same edge: done = 1 and ovf = 0.
REQ-026 Start and clear in one write: both take effect; the clear does not cancel the start.
REQ-027 Writes to addresses 6 and 7 are ignored.

Reset
REQ-028 While i_reset_n = 0, the block asynchronously sets: A, B, X, C, RES_LO, RES_HI and o_data to 0; K to K_RESET; all stage valids, done, ovf and ie to 0; o_irq to 0.
REQ-029 Reset mid-operation discards all in-flight operations; no done is produced afterwards for them.
REQ-030 The first rising edge after deassertion operates normally.

Configuration
REQ-031 Macro RF_ACCEL_IRQ_EN.
REQ-032 With RF_ACCEL_IRQ_EN defined: the ie bit is stored, and o_irq = done AND ie, registered with the status bits.
REQ-033 Without RF_ACCEL_IRQ_EN: no o_irq port exists, ie is not stored, and STATUS bit3 reads 0.

Verification
REQ-034 Basic: A=2, B=3, K=3, X=5, C=7, start at edge t -> at edge t+4 RES_LO=55, RES_HI=0, done=1; busy=1 over edges t..t+3.
REQ-035 Wrap: N=32, A=B=X=0xFFFFFFFF, K=0, C=0, start -> RES_HI=0x00000002, RES_LO=0xFFFFFFFF.
REQ-036 Back-to-back: start with X=1 and then X=2 on consecutive cycles (A=B=1, K=0, C=0) -> RES_LO=1 at t+4 and RES_LO=2 at t+5; ovf=1 after t+5.
REQ-037 Clear race: issue clear on the edge a result lands -> done=1, ovf=0.
REQ-038 Reset: assert i_reset_n=0 two cycles after a start -> done stays 0, RES_*=0, K reads 3.
REQ-039 IRQ (macro defined): ie=1, then run the REQ-034 operation -> o_irq=1 at t+4; clear -> o_irq=0 next cycle.
